// File: rtl/rv_wb_pkg.sv
// Shared types for the writeback / register-file write path.
//   rf_idx_t  : architectural register index (x0..x31)
//   rf_data_t : register data word
//   wb_req_t  : one pending write (destination + data)
package rv_wb_pkg;

  typedef logic [4:0]  rf_idx_t;
  typedef logic [31:0] rf_data_t;

  typedef struct packed {
    rf_idx_t  rd;
    rf_data_t data;
  } wb_req_t;

  localparam rf_idx_t RF_X0 = 5'd0;

  // One-hot scoreboard bit for a destination register.
  function automatic logic [31:0] rd_onehot(input rf_idx_t rd);
    return 32'd1 << rd;
  endfunction

endpackage

// File: rtl/rv_rr_arbiter.sv
// Generic N-way round-robin arbiter with a registered rotating pointer.
// Ports:
//   i_clk       clock, rising edge
//   i_reset     synchronous active-high reset (pointer back to 0)
//   i_req       request vector, one bit per requester
//   i_en        grant enable; when 0 nothing is granted and the pointer holds
//   o_gnt       one-hot grant (combinational)
//   o_gnt_idx   index of the granted requester
//   o_gnt_any   a grant was issued this cycle
module rv_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N-1:0]     i_req,
  input  logic             i_en,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_any
);

  logic [IDX_W-1:0] ptr;

  // Search starts at the pointer and wraps; first valid requester wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!o_gnt_any && i_en && i_req[(int'(ptr) + off) % N]) begin
        o_gnt_any                      = 1'b1;
        o_gnt[(int'(ptr) + off) % N]   = 1'b1;
        o_gnt_idx                      = IDX_W'((int'(ptr) + off) % N);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr <= '0;
    end else if (o_gnt_any) begin
      ptr <= IDX_W'((int'(o_gnt_idx) + 1) % N);
    end
  end

endmodule

// File: rtl/rv_wb_arbiter.sv
// Writeback arbiter owning the single register-file write port.
// The in-order pipeline has fixed priority; NUM_REQ long-latency units share
// the leftover slots round-robin via valid/ready. A starvation counter forces
// one-cycle pipeline holds, and a scoreboard tracks pending async destinations.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_pipe_we/rd/data              pipeline writeback request
//   o_pipe_hold                    registered; pipeline write suppressed this cycle
//   i_req_valid/rd/data            packed async requests (unit i at slice i)
//   o_req_ready                    combinational one-hot grant
//   i_issue_valid/rd               async op dispatch (sets scoreboard bit)
//   o_busy_mask                    registered pending-destination scoreboard
//   o_rf_we/rd/data                registered register-file write port
module rv_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_pipe_we,
  input  logic [4:0]            i_pipe_rd,
  input  logic [31:0]           i_pipe_data,
  output logic                  o_pipe_hold,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [5*NUM_REQ-1:0]  i_req_rd,
  input  logic [32*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic                  i_issue_valid,
  input  logic [4:0]            i_issue_rd,
  output logic [31:0]           o_busy_mask,
  output logic                  o_rf_we,
  output logic [4:0]            o_rf_rd,
  output logic [31:0]           o_rf_data
);

  localparam int        IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic             pipe_write;
  logic             arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  wb_req_t          reqs [NUM_REQ];
  wb_req_t          win;
  logic [7:0]       starve_cnt;
  logic             any_valid;
  logic [31:0]      mask_next;

  // A pipeline write to x0 is not a real write and leaves the slot free.
  assign pipe_write = i_pipe_we && (i_pipe_rd != RF_X0) && !o_pipe_hold;
  assign arb_en     = !i_reset && !pipe_write;
  assign any_valid  = |i_req_valid;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqs[i].rd   = i_req_rd[5*i +: 5];
      reqs[i].data = i_req_data[32*i +: 32];
    end
  end

  assign win = reqs[gnt_idx];

  rv_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_req     (i_req_valid),
    .i_en      (arb_en),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx),
    .o_gnt_any (gnt_any)
  );

  assign o_req_ready = gnt;

  // Write port: rd/data only move on a real write, so idle cycles and x0
  // grants leave the last written index/data visible.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rf_we   <= 1'b0;
      o_rf_rd   <= '0;
      o_rf_data <= '0;
    end else if (pipe_write) begin
      o_rf_we   <= 1'b1;
      o_rf_rd   <= i_pipe_rd;
      o_rf_data <= i_pipe_data;
    end else if (gnt_any && (win.rd != RF_X0)) begin
      o_rf_we   <= 1'b1;
      o_rf_rd   <= win.rd;
      o_rf_data <= win.data;
    end else begin
      o_rf_we   <= 1'b0;
    end
  end

  // Starvation: the counter saturates at LIMIT; sitting at LIMIT schedules a
  // single hold cycle and clears the counter, so holds cannot be back to back.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      starve_cnt  <= '0;
      o_pipe_hold <= 1'b0;
    end else begin
      o_pipe_hold <= (starve_cnt == LIMIT) && !o_pipe_hold;
      if (gnt_any || (starve_cnt == LIMIT)) begin
        starve_cnt <= '0;
      end else if (any_valid) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

  // Scoreboard: clear on async grant, then set on issue so set wins.
  always_comb begin
    mask_next = o_busy_mask;
    if (gnt_any && (win.rd != RF_X0)) begin
      mask_next = mask_next & ~rd_onehot(win.rd);
    end
    if (i_issue_valid && (i_issue_rd != RF_X0)) begin
      mask_next = mask_next | rd_onehot(i_issue_rd);
    end
    mask_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_busy_mask <= '0;
    end else begin
      o_busy_mask <= mask_next;
    end
  end

endmodule

// File: tb/tb_rv_wb_arbiter.sv
module tb_rv_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_pipe_we;
  logic [4:0]  i_pipe_rd;
  logic [31:0] i_pipe_data;
  logic        o_pipe_hold;
  logic [1:0]  i_req_valid;
  logic [9:0]  i_req_rd;
  logic [63:0] i_req_data;
  logic [1:0]  o_req_ready;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic [31:0] o_busy_mask;
  logic        o_rf_we;
  logic [4:0]  o_rf_rd;
  logic [31:0] o_rf_data;

  always #5 i_clk = ~i_clk;

  rv_wb_arbiter #(.NUM_REQ(2), .STARVE_LIMIT(8)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_pipe_we     (i_pipe_we),
    .i_pipe_rd     (i_pipe_rd),
    .i_pipe_data   (i_pipe_data),
    .o_pipe_hold   (o_pipe_hold),
    .i_req_valid   (i_req_valid),
    .i_req_rd      (i_req_rd),
    .i_req_data    (i_req_data),
    .o_req_ready   (o_req_ready),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .o_busy_mask   (o_busy_mask),
    .o_rf_we       (o_rf_we),
    .o_rf_rd       (o_rf_rd),
    .o_rf_data     (o_rf_data)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic [1:0]  rv;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        iv;
    logic [4:0]  ird;
    logic [1:0]  e_rdy;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [31:0] e_mask;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pdata,
                       input logic [1:0] rv, input logic [4:0] rd0, input logic [4:0] rd1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic iv, input logic [4:0] ird);
    i_pipe_we     = pwe;
    i_pipe_rd     = prd;
    i_pipe_data   = pdata;
    i_req_valid   = rv;
    i_req_rd      = {rd1, rd0};
    i_req_data    = {d1, d0};
    i_issue_valid = iv;
    i_issue_rd    = ird;
  endtask

  // Async protocol monitor: a denied valid must still be valid next cycle.
  logic [1:0] pend = 2'b00;
  always @(posedge i_clk) begin
    if (!i_reset && ((pend & ~i_req_valid) != 2'b00)) begin
      errors++;
      $display("FAIL protocol: valid %b dropped while pending %b", i_req_valid, pend);
    end
    pend <= i_req_valid & ~o_req_ready & {2{~i_reset}};
  end

  initial begin
    //            pwe  prd    pdata          rv     rd0    rd1    d0             d1             iv   ird    rdy    we    rd     data           mask
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 2'b01, 5'd7,  5'd0,  32'h77770007, 32'h0,        1'b1, 5'd7,  2'b00, 1'b1, 5'd5,  32'hDEADBEEF, 32'h00000080};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd7,  5'd0,  32'h77770007, 32'h0,        1'b0, 5'd0,  2'b01, 1'b1, 5'd7,  32'h77770007, 32'h00000000};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        2'b10, 5'd0,  5'd4,  32'h0,        32'h44,       1'b0, 5'd0,  2'b10, 1'b1, 5'd4,  32'h44,       32'h00000000};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd3,  5'd4,  32'h33,       32'h44,       1'b0, 5'd0,  2'b01, 1'b1, 5'd3,  32'h33,       32'h00000000};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd3,  5'd4,  32'h33,       32'h44,       1'b0, 5'd0,  2'b10, 1'b1, 5'd4,  32'h44,       32'h00000000};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd3,  5'd4,  32'h33,       32'h44,       1'b0, 5'd0,  2'b01, 1'b1, 5'd3,  32'h33,       32'h00000000};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd3,  5'd4,  32'h33,       32'h44,       1'b0, 5'd0,  2'b10, 1'b1, 5'd4,  32'h44,       32'h00000000};
    vecs[7]  = '{1'b1, 5'd0,  32'h5A5A,     2'b01, 5'd3,  5'd0,  32'h33,       32'h0,        1'b1, 5'd0,  2'b01, 1'b1, 5'd3,  32'h33,       32'h00000000};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd0,  5'd0,  32'hAA,       32'h0,        1'b0, 5'd0,  2'b01, 1'b0, 5'd3,  32'h33,       32'h00000000};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd9,  2'b00, 1'b0, 5'd3,  32'h33,       32'h00000200};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd10, 2'b00, 1'b0, 5'd3,  32'h33,       32'h00000600};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd9,  5'd0,  32'h99,       32'h0,        1'b1, 5'd9,  2'b01, 1'b1, 5'd9,  32'h99,       32'h00000600};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        2'b10, 5'd0,  5'd10, 32'h0,        32'h1010,     1'b0, 5'd0,  2'b10, 1'b1, 5'd10, 32'h1010,     32'h00000200};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  2'b00, 1'b0, 5'd10, 32'h1010,     32'h00000200};

    // Reset with traffic present.
    i_reset = 1'b1;
    drive(1'b1, 5'd2, 32'h22, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 1'b1, 5'd6);
    #1;
    chk("reset ready", 32'(o_req_ready), 32'h0);
    cyc();
    cyc();
    chk("reset rf_we", 32'(o_rf_we), 32'h0);
    chk("reset rf_rd", 32'(o_rf_rd), 32'h0);
    chk("reset rf_data", o_rf_data, 32'h0);
    chk("reset hold", 32'(o_pipe_hold), 32'h0);
    chk("reset mask", o_busy_mask, 32'h0);
    i_reset = 1'b0;

    // Table-driven single-cycle vectors; state carries from row to row.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].pwe, vecs[i].prd, vecs[i].pdata, vecs[i].rv, vecs[i].rd0, vecs[i].rd1,
            vecs[i].d0, vecs[i].d1, vecs[i].iv, vecs[i].ird);
      #1;
      chk($sformatf("v%0d ready", i), 32'(o_req_ready), 32'(vecs[i].e_rdy));
      cyc();
      chk($sformatf("v%0d rf_we", i), 32'(o_rf_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d rf_rd", i), 32'(o_rf_rd), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d rf_data", i), o_rf_data, vecs[i].e_data);
      chk($sformatf("v%0d mask", i), o_busy_mask, vecs[i].e_mask);
    end

    // Starvation: pipe writes x1 every cycle, unit 1 waits. The counter hits
    // the limit after 8 denied cycles, so the hold shows up on cycle 9.
    for (int k = 0; k <= 10; k++) begin
      drive(1'b1, 5'd1, 32'h1111, (k <= 9) ? 2'b10 : 2'b00, 5'd0, 5'd17,
            32'h0, 32'hABCD, 1'b0, 5'd0);
      #1;
      chk($sformatf("starve k%0d hold", k), 32'(o_pipe_hold), (k == 9) ? 32'h1 : 32'h0);
      chk($sformatf("starve k%0d ready", k), 32'(o_req_ready), (k == 9) ? 32'h2 : 32'h0);
      cyc();
      if (k == 9) begin
        chk("starve grant rf_rd", 32'(o_rf_rd), 32'd17);
        chk("starve grant rf_data", o_rf_data, 32'hABCD);
        chk("starve grant rf_we", 32'(o_rf_we), 32'h1);
      end
      if (k == 10) begin
        chk("starve replay rf_rd", 32'(o_rf_rd), 32'd1);
        chk("starve replay rf_data", o_rf_data, 32'h1111);
      end
    end

    // Move the RR pointer to 1, make the mask non-zero, then reset mid-traffic.
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 32'h33, 32'h0, 1'b0, 5'd0);
    #1;
    chk("pre-reset ready", 32'(o_req_ready), 32'h1);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd12);
    cyc();
    chk("pre-reset mask", o_busy_mask, 32'h00001200);
    i_reset = 1'b1;
    drive(1'b1, 5'd2, 32'h22, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 1'b0, 5'd0);
    #1;
    chk("mid reset ready", 32'(o_req_ready), 32'h0);
    cyc();
    chk("mid reset rf_we", 32'(o_rf_we), 32'h0);
    chk("mid reset mask", o_busy_mask, 32'h0);
    chk("mid reset hold", 32'(o_pipe_hold), 32'h0);
    i_reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 1'b0, 5'd0);
    #1;
    chk("post reset first ready", 32'(o_req_ready), 32'h1);
    cyc();
    chk("post reset rf_rd", 32'(o_rf_rd), 32'd3);
    drive(1'b0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd4, 32'h0, 32'h44, 1'b0, 5'd0);
    #1;
    chk("post reset second ready", 32'(o_req_ready), 32'h2);
    cyc();
    chk("post reset rf_rd2", 32'(o_rf_rd), 32'd4);
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    cyc();
    chk("idle rf_we", 32'(o_rf_we), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
